// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared constants for the pipeline datapath muxes.
//   XLEN       : native datapath word width, default width of every mux.
//   RESET_WORD : word loaded into a mux output register on reset.
//   SEL_A/B    : named select codes, SEL_A picks input A, SEL_B picks input B.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_WORD = '0;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : pipe_pkg

// File: rtl/dff_ar.sv
// dff_ar
//   WIDTH-bit register with asynchronous active-high reset to RESET_VAL.
//   Ports:
//     clk : clock, loads on rising edge
//     rst : asynchronous active-high reset, forces q to RESET_VAL at once
//     d   : next-state word
//     q   : registered word
module dff_ar #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : dff_ar

// File: rtl/mux_2to1.sv
// mux_2to1
//   Registered 2-to-1 word multiplexer for the pipeline datapath
//   (operand select, PC select). The chosen word appears on result one
//   clock after it is presented; there is no enable, every non-reset edge loads.
//   Ports:
//     clk    : clock, rising edge
//     rst    : asynchronous active-high reset, result <= RESET_VAL at once
//     sel    : select, SEL_A (0) picks ina, SEL_B (1) picks inb
//     ina    : data input 0
//     inb    : data input 1
//     result : registered selected word
module mux_2to1
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] w_next;

  // Select stays inline; only the storage lives in the sub-module so that
  // result comes straight off a flop with no input-to-output path.
  assign w_next = (sel == SEL_B) ? inb : ina;

  dff_ar #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_result_reg (
    .clk (clk),
    .rst (rst),
    .d   (w_next),
    .q   (result)
  );

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1
//   Self-checking bench for mux_2to1: a default 32-bit instance and an
//   8-bit instance with RESET_VAL 0x5A, driven by directed and random stimulus.
module tb_mux_2to1;
  import pipe_pkg::*;

  localparam logic [7:0] RV8 = 8'h5A;

  logic            clk = 1'b0;
  logic            rst;
  logic            sel;
  logic [XLEN-1:0] ina;
  logic [XLEN-1:0] inb;
  logic [XLEN-1:0] result;

  logic            rst8;
  logic            sel8;
  logic [7:0]      ina8;
  logic [7:0]      inb8;
  logic [7:0]      result8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_2to1 dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .ina    (ina),
    .inb    (inb),
    .result (result)
  );

  mux_2to1 #(
    .WIDTH     (8),
    .RESET_VAL (RV8)
  ) dut8 (
    .clk    (clk),
    .rst    (rst8),
    .sel    (sel8),
    .ina    (ina8),
    .inb    (inb8),
    .result (result8)
  );

  // Reference: the word a registered 2-way select must show after one edge.
  function automatic logic [XLEN-1:0] pick32(input logic s, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    if (s) return b;
    return a;
  endfunction

  function automatic logic [7:0] pick8(input logic s, input logic [7:0] a, input logic [7:0] b);
    if (s) return b;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sel  = 1'b1;
    ina  = 32'h0000_0000;
    inb  = 32'h0000_0001;
    rst8 = 1'b1;
    sel8 = 1'b0;
    ina8 = 8'h00;
    inb8 = 8'hFF;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL reset_pre_edge: got %h want %h", result, 32'h0);
    end
    checks++;
    if (result8 !== RV8) begin
      errors++;
      $display("FAIL reset8_pre_edge: got %h want %h", result8, RV8);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (result !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, result, 32'h0);
      end
      $display("reset edge %0d result=%h", i, result);
    end
  endtask

  task automatic test_sel0();
    sel = SEL_A;
    ina = 32'h0000_0000;
    inb = 32'h0000_0001;
    rst = 1'b0;
    step();
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL sel0_zero: got %h want %h", result, 32'h0);
    end
    ina = 32'hDEAD_BEEF;
    step();
    checks++;
    if (result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sel0_deadbeef: got %h want %h", result, 32'hDEAD_BEEF);
    end
    $display("sel0 result=%h", result);
  endtask

  task automatic test_sel1();
    sel = SEL_B;
    ina = 32'h0000_0000;
    inb = 32'h0000_0001;
    step();
    checks++;
    if (result !== 32'h1) begin
      errors++;
      $display("FAIL sel1_one: got %h want %h", result, 32'h1);
    end
    inb = 32'hFFFF_FFFF;
    step();
    checks++;
    if (result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sel1_ones: got %h want %h", result, 32'hFFFF_FFFF);
    end
    $display("sel1 result=%h", result);
  endtask

  task automatic test_toggle();
    logic [XLEN-1:0] want_q[$];
    logic [XLEN-1:0] want;
    want_q = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555};
    ina = 32'hAAAA_AAAA;
    inb = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      sel = (i % 2 == 1);
      step();
      want = want_q.pop_front();
      checks++;
      if (result !== want) begin
        errors++;
        $display("FAIL toggle[%0d]: got %h want %h", i, result, want);
      end
      $display("toggle %0d sel=%0b result=%h", i, sel, result);
    end
    // Reset pulse between edges: output must clear without a clock.
    sel = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL midreset_clear: got %h want %h", result, 32'h0);
    end
    rst = 1'b0;
    sel = 1'b1;
    step();
    checks++;
    if (result !== 32'h5555_5555) begin
      errors++;
      $display("FAIL midreset_reload: got %h want %h", result, 32'h5555_5555);
    end
    $display("midreset reload result=%h", result);
  endtask

  task automatic test_equal_inputs();
    logic [XLEN-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v   = $urandom;
      ina = v;
      inb = v;
      sel = $urandom_range(0, 1);
      step();
      checks++;
      if (result !== v) begin
        errors++;
        $display("FAIL equal[%0d]: got %h want %h", i, result, v);
      end
      $display("equal %0d sel=%0b result=%h", i, sel, result);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] want;
    for (int i = 0; i < 64; i++) begin
      sel  = $urandom_range(0, 1);
      ina  = $urandom;
      inb  = $urandom;
      want = pick32(sel, ina, inb);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0) begin
          errors++;
          $display("FAIL rand_reset[%0d]: got %h want %h", i, result, 32'h0);
        end
        rst = 1'b0;
      end
      step();
      checks++;
      if (result !== want) begin
        errors++;
        $display("FAIL rand[%0d]: got %h want %h", i, result, want);
      end
      $display("rand %0d sel=%0b a=%h b=%h result=%h", i, sel, ina, inb, result);
    end
  endtask

  task automatic test_width8();
    logic [7:0] want;
    step();
    checks++;
    if (result8 !== RV8) begin
      errors++;
      $display("FAIL w8_reset_hold: got %h want %h", result8, RV8);
    end
    sel8 = SEL_A;
    ina8 = 8'h80;
    inb8 = 8'h7F;
    rst8 = 1'b0;
    step();
    checks++;
    if (result8 !== 8'h80) begin
      errors++;
      $display("FAIL w8_sel0: got %h want %h", result8, 8'h80);
    end
    $display("w8 sel0 result=%h", result8);
    for (int i = 0; i < 16; i++) begin
      sel8 = $urandom_range(0, 1);
      ina8 = 8'($urandom);
      inb8 = 8'($urandom);
      want = pick8(sel8, ina8, inb8);
      step();
      checks++;
      if (result8 !== want) begin
        errors++;
        $display("FAIL w8_rand[%0d]: got %h want %h", i, result8, want);
      end
      $display("w8 rand %0d sel=%0b result=%h", i, sel8, result8);
    end
    rst8 = 1'b1;
    #1;
    checks++;
    if (result8 !== RV8) begin
      errors++;
      $display("FAIL w8_midreset: got %h want %h", result8, RV8);
    end
    rst8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sel0();
    test_sel1();
    test_toggle();
    test_equal_inputs();
    test_random();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_2to1
